// File: rtl/fila_window_reader_if.sv
// Bundle of FIFO read handshake, window output handshake and row status for
// fila_window_reader. master = the window reader, slave = FIFO + filter side.
interface fila_window_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int COL_BITS   = 5
);
  logic                  enable;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  read_req;
  logic                  read_en;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] pix_left;
  logic [DATA_WIDTH-1:0] pix_center;
  logic [DATA_WIDTH-1:0] pix_right;
  logic                  window_valid;
  logic                  row_done;
  logic [COL_BITS-1:0]   col_count;

  modport master (
    input  enable, fifo_data, fifo_empty, out_ready,
    output read_req, read_en, pix_left, pix_center, pix_right,
           window_valid, row_done, col_count
  );

  modport slave (
    output enable, fifo_data, fifo_empty, out_ready,
    input  read_req, read_en, pix_left, pix_center, pix_right,
           window_valid, row_done, col_count
  );
endinterface

// File: rtl/fila_window_reader.sv
// Pulls pixels one at a time from a row FIFO into a 3-pixel horizontal window
// and hands complete windows downstream; one read outstanding at a time.
module fila_window_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMAGE_WIDTH = 16,
  parameter int COL_BITS    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  fila_window_reader_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_EMIT,
    S_ROW_END
  } state_e;

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMAGE_WIDTH);

  state_e                state_q, state_d;
  logic [1:0]            fill_q, fill_d;
  logic [COL_BITS-1:0]   col_q, col_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] center_q, center_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    col_d    = col_q;
    left_d   = left_q;
    center_d = center_q;
    right_d  = right_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable && !bus.fifo_empty) state_d = S_READ;
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // fifo_data is valid now, one cycle after the read request.
        left_d   = center_q;
        center_d = right_q;
        right_d  = bus.fifo_data;
        col_d    = col_q + COL_BITS'(1);
        fill_d   = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
        state_d  = (fill_d == 2'd3) ? S_EMIT : S_IDLE;
      end
      S_EMIT: begin
        if (bus.out_ready) state_d = (col_q == LAST_COL) ? S_ROW_END : S_IDLE;
      end
      S_ROW_END: begin
        // Wipe the window so the next row never reuses pixels from this one.
        fill_d   = '0;
        col_d    = '0;
        left_d   = '0;
        center_d = '0;
        right_d  = '0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments; the async reset also aborts an in-flight READ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      fill_q   <= '0;
      col_q    <= '0;
      left_q   <= '0;
      center_q <= '0;
      right_q  <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      col_q    <= col_d;
      left_q   <= left_d;
      center_q <= center_d;
      right_q  <= right_d;
    end
  end

  // Moore outputs: decoded only from registered state.
  assign bus.read_req     = (state_q == S_READ);
  assign bus.read_en      = (state_q == S_READ);
  assign bus.window_valid = (state_q == S_EMIT);
  assign bus.row_done     = (state_q == S_ROW_END);
  assign bus.col_count    = col_q;
  assign bus.pix_left     = left_q;
  assign bus.pix_center   = center_q;
  assign bus.pix_right    = right_q;

endmodule

// File: tb/tb_fila_window_reader.sv
// Directed bench for fila_window_reader: a 5-wide instance for reset, single row,
// backpressure, empty FIFO and mid-row reset; a 4-wide instance for back-to-back rows.
module tb_fila_window_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst5_n;
  logic rst4_n;

  fila_window_reader_if #(.DATA_WIDTH(8), .COL_BITS(5)) if5 ();
  fila_window_reader_if #(.DATA_WIDTH(8), .COL_BITS(5)) if4 ();

  fila_window_reader #(.DATA_WIDTH(8), .IMAGE_WIDTH(5), .COL_BITS(5)) u5 (
    .clk   (clk),
    .reset (rst5_n),
    .bus   (if5.master)
  );

  fila_window_reader #(.DATA_WIDTH(8), .IMAGE_WIDTH(4), .COL_BITS(5)) u4 (
    .clk   (clk),
    .reset (rst4_n),
    .bus   (if4.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO models: data appears on fifo_data the cycle after read_req.
  logic [7:0] mem5 [0:63];
  logic [7:0] mem4 [0:63];
  int push5 = 0, pop5 = 0, push4 = 0, pop4 = 0;
  int wide5 = 0, wide4 = 0, done4 = 0, done5 = 0, en_bad = 0;
  logic prev5 = 1'b0, prev4 = 1'b0;

  assign if5.fifo_empty = (push5 == pop5);
  assign if4.fifo_empty = (push4 == pop4);

  always @(posedge clk) begin
    if (if5.read_req) begin
      if5.fifo_data <= mem5[pop5[5:0]];
      pop5 <= pop5 + 1;
    end
    if (if4.read_req) begin
      if4.fifo_data <= mem4[pop4[5:0]];
      pop4 <= pop4 + 1;
    end
    if (if5.read_req && prev5) wide5 <= wide5 + 1;
    if (if4.read_req && prev4) wide4 <= wide4 + 1;
    prev5 <= if5.read_req;
    prev4 <= if4.read_req;
    if (if5.row_done) done5 <= done5 + 1;
    if (if4.row_done) done4 <= done4 + 1;
    if ((if5.read_en !== if5.read_req) || (if4.read_en !== if4.read_req)) en_bad <= en_bad + 1;
  end

  task automatic push(input int sel, input logic [7:0] v);
    if (sel == 5) begin
      mem5[push5[5:0]] = v;
      push5++;
    end else begin
      mem4[push4[5:0]] = v;
      push4++;
    end
  endtask

  task automatic sample(input int sel, output logic v, output logic [23:0] win,
                        output logic [4:0] col, output logic rq, output logic rd);
    if (sel == 5) begin
      v   = if5.window_valid;
      win = {if5.pix_left, if5.pix_center, if5.pix_right};
      col = if5.col_count;
      rq  = if5.read_req;
      rd  = if5.row_done;
    end else begin
      v   = if4.window_valid;
      win = {if4.pix_left, if4.pix_center, if4.pix_right};
      col = if4.col_count;
      rq  = if4.read_req;
      rd  = if4.row_done;
    end
  endtask

  // Waits (bounded) for the next window_valid and compares its pixels.
  task automatic wait_window(input int sel, input logic [7:0] el, input logic [7:0] ec,
                             input logic [7:0] er, input string name);
    logic v, rq, rd;
    logic [23:0] win;
    logic [4:0] col;
    v = 1'b0;
    for (int i = 0; i < 40 && !v; i++) begin
      @(negedge clk);
      sample(sel, v, win, col, rq, rd);
    end
    n_checks++;
    if (!v) begin
      n_fail++;
      $display("FAIL %s: window_valid never rose (timeout)", name);
    end else if (win !== {el, ec, er}) begin
      n_fail++;
      $display("FAIL %s: window got %0d,%0d,%0d expected %0d,%0d,%0d", name,
               win[23:16], win[15:8], win[7:0], el, ec, er);
    end
  endtask

  // Waits (bounded) for row_done, then checks the row state was cleared.
  task automatic wait_row_done(input int sel, input string name);
    logic v, rq, rd;
    logic [23:0] win;
    logic [4:0] col;
    rd = 1'b0;
    for (int i = 0; i < 20 && !rd; i++) begin
      @(negedge clk);
      sample(sel, v, win, col, rq, rd);
    end
    n_checks++;
    if (!rd) begin
      n_fail++;
      $display("FAIL %s: row_done never pulsed (timeout)", name);
    end
    @(negedge clk);
    sample(sel, v, win, col, rq, rd);
    n_checks++;
    if ({rd, col, win} !== 30'd0) begin
      n_fail++;
      $display("FAIL %s_clear: row_done=%b col=%0d win=%h expected all zero", name, rd, col, win);
    end
  endtask

  task automatic check_col(input int sel, input logic [4:0] exp, input string name);
    logic v, rq, rd;
    logic [23:0] win;
    logic [4:0] col;
    sample(sel, v, win, col, rq, rd);
    n_checks++;
    if (col !== exp) begin
      n_fail++;
      $display("FAIL %s: col_count=%0d expected %0d", name, col, exp);
    end
  endtask

  task automatic test_reset;
    rst5_n = 1'b0;
    rst4_n = 1'b0;
    if5.enable = 1'b1;
    if5.out_ready = 1'b1;
    if4.enable = 1'b1;
    if4.out_ready = 1'b1;
    push(5, 8'd10); push(5, 8'd20); push(5, 8'd30); push(5, 8'd40); push(5, 8'd50);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({if5.read_req, if5.read_en, if5.window_valid, if5.row_done, if5.col_count,
         if5.pix_left, if5.pix_center, if5.pix_right} !== 33'd0 || pop5 != 0) begin
      n_fail++;
      $display("FAIL reset_outputs: outputs not zero or reads=%0d during reset", pop5);
    end
    rst5_n = 1'b1;
    #1;
    n_checks++;
    if (if5.read_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: read_req=%b expected 0 before first edge", if5.read_req);
    end
    @(negedge clk);
    n_checks++;
    if (if5.read_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_latency: read_req=%b expected 1 after first edge", if5.read_req);
    end
  endtask

  task automatic test_single_row;
    wait_window(5, 8'd10, 8'd20, 8'd30, "row_w0");
    check_col(5, 5'd3, "row_w0_col");
    wait_window(5, 8'd20, 8'd30, 8'd40, "row_w1");
    wait_window(5, 8'd30, 8'd40, 8'd50, "row_w2");
    check_col(5, 5'd5, "row_w2_col");
    wait_row_done(5, "row_done");
    n_checks++;
    if (pop5 != 5 || wide5 != 0 || done5 != 1) begin
      n_fail++;
      $display("FAIL row_counts: reads=%0d wide=%0d row_done=%0d expected 5,0,1", pop5, wide5, done5);
    end
  endtask

  task automatic test_backpressure;
    int base;
    if5.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(5, 8'(i));
    wait_window(5, 8'd1, 8'd2, 8'd3, "bp_w0");
    base = pop5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({if5.window_valid, if5.read_req, if5.pix_left, if5.pix_center, if5.pix_right} !==
          {1'b1, 1'b0, 8'd1, 8'd2, 8'd3}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b req=%b win=%0d,%0d,%0d expected 1,0,1,2,3", i,
                 if5.window_valid, if5.read_req, if5.pix_left, if5.pix_center, if5.pix_right);
      end
    end
    n_checks++;
    if (pop5 != base) begin
      n_fail++;
      $display("FAIL bp_no_read: reads=%0d expected %0d", pop5, base);
    end
    if5.out_ready = 1'b1;
    wait_window(5, 8'd2, 8'd3, 8'd4, "bp_w1");
    wait_window(5, 8'd3, 8'd4, 8'd5, "bp_w2");
    wait_row_done(5, "bp_row_done");
  endtask

  task automatic test_empty_fifo;
    push(5, 8'd7);
    push(5, 8'd8);
    repeat (12) @(negedge clk);
    n_checks++;
    if ({if5.col_count, if5.window_valid, if5.read_req} !== {5'd2, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL empty_park: col=%0d valid=%b req=%b expected 2,0,0",
               if5.col_count, if5.window_valid, if5.read_req);
    end
    push(5, 8'd9);
    wait_window(5, 8'd7, 8'd8, 8'd9, "empty_w0");
    push(5, 8'd11);
    push(5, 8'd12);
    wait_window(5, 8'd8, 8'd9, 8'd11, "empty_w1");
    wait_window(5, 8'd9, 8'd11, 8'd12, "empty_w2");
    wait_row_done(5, "empty_row_done");
  endtask

  task automatic test_mid_row_reset;
    int base;
    logic hit;
    base = pop5;
    for (int i = 21; i <= 26; i++) push(5, 8'(i));
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = (if5.read_req === 1'b1) && (if5.col_count === 5'd2);
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mrr_find: READ of pixel 3 not seen (timeout)");
    end
    rst5_n = 1'b0;
    #1;
    n_checks++;
    if ({if5.read_req, if5.col_count, if5.window_valid} !== 7'd0) begin
      n_fail++;
      $display("FAIL mrr_async: req=%b col=%0d valid=%b expected 0,0,0",
               if5.read_req, if5.col_count, if5.window_valid);
    end
    @(negedge clk);
    rst5_n = 1'b1;
    n_checks++;
    if (pop5 - base != 2) begin
      n_fail++;
      $display("FAIL mrr_reads: pixels read=%0d expected 2", pop5 - base);
    end
    push(5, 8'd27);
    wait_window(5, 8'd23, 8'd24, 8'd25, "mrr_w0");
    wait_window(5, 8'd24, 8'd25, 8'd26, "mrr_w1");
    wait_window(5, 8'd25, 8'd26, 8'd27, "mrr_w2");
    wait_row_done(5, "mrr_row_done");
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 8; i++) push(4, 8'(i));
    @(negedge clk);
    rst4_n = 1'b1;
    wait_window(4, 8'd1, 8'd2, 8'd3, "b2b_w0");
    wait_window(4, 8'd2, 8'd3, 8'd4, "b2b_w1");
    wait_window(4, 8'd5, 8'd6, 8'd7, "b2b_w2");
    wait_window(4, 8'd6, 8'd7, 8'd8, "b2b_w3");
    wait_row_done(4, "b2b_row_done");
    n_checks++;
    if (done4 != 2 || pop4 != 8 || wide4 != 0) begin
      n_fail++;
      $display("FAIL b2b_counts: row_done=%0d reads=%0d wide=%0d expected 2,8,0", done4, pop4, wide4);
    end
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_empty_fifo();
    test_mid_row_reset();
    test_back_to_back();
    n_checks++;
    if (en_bad != 0) begin
      n_fail++;
      $display("FAIL read_en_match: read_en differed from read_req %0d times, expected 0", en_bad);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
